tx_fifo_read: RTL

- Transmit-side counterpart of the RX FIFO packer.
- Pops 128-bit packed words from a first-word-fall-through (FWFT) FIFO and unpacks them into one sample per beat on an AXI-Stream master, according to data_format.
- Sits between the host-filled TX FIFO and the DAC/DSP datapath in the data_clk domain.
- Sample lane layout on m_axis_tdata: I lane [63:0], Q lane [127:64].

---
 rtl/tx_rx_fifo_pkg.sv | 36 +++
 rtl/sample_unpack_mux.sv | 70 +++++++
 rtl/tx_fifo_read.sv | 89 ++++++++
 3 files changed

// File: rtl/tx_rx_fifo_pkg.sv
// Types and helpers shared by the TX FIFO reader and the RX FIFO packer.
// Formats encode sample width and complex/real; words are always 128 bits.
package tx_rx_fifo_pkg;

   typedef enum logic [2:0] {
      FMT_C64 = 3'd0,
      FMT_R64 = 3'd1,
      FMT_C32 = 3'd2,
      FMT_R32 = 3'd3,
      FMT_C16 = 3'd4,
      FMT_R16 = 3'd5,
      FMT_C8  = 3'd6,
      FMT_R8  = 3'd7
   } fmt_e;

   localparam int I_LSB = 0;
   localparam int Q_LSB = 64;

   function automatic logic [4:0] samples_per_word(input fmt_e fmt);
      logic [4:0] n;
      n = 5'd1;
      case (fmt)
         FMT_C64: n = 5'd1;
         FMT_R64: n = 5'd2;
         FMT_C32: n = 5'd2;
         FMT_R32: n = 5'd4;
         FMT_C16: n = 5'd4;
         FMT_R16: n = 5'd8;
         FMT_C8:  n = 5'd8;
         FMT_R8:  n = 5'd16;
         default: n = 5'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sample_unpack_mux.sv
// Selects sample idx from a packed 128-bit word and sign-extends it onto the
// I/Q lanes. Purely combinational; real formats leave the Q lane zero.
module sample_unpack_mux
   import tx_rx_fifo_pkg::*;
(
   input  logic [127:0] word,
   input  logic [3:0]   idx,
   input  fmt_e         fmt,
   output logic [127:0] tdata
);

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] sx16(input logic [15:0] v);
      return {{48{v[15]}}, v};
   endfunction

   function automatic logic [63:0] sx8(input logic [7:0] v);
      return {{56{v[7]}}, v};
   endfunction

   logic [63:0] sh;

   // The slot is shifted down to bit 0 first, then split into I and Q halves.
   always_comb begin
      tdata = '0;
      sh    = '0;
      case (fmt)
         FMT_C64: begin
            tdata[I_LSB +: 64] = word[63:0];
            tdata[Q_LSB +: 64] = word[127:64];
         end
         FMT_R64: begin
            sh = 64'(word >> {idx[0], 6'd0});
            tdata[I_LSB +: 64] = sh;
         end
         FMT_C32: begin
            sh = 64'(word >> {idx[0], 6'd0});
            tdata[I_LSB +: 64] = sx32(sh[31:0]);
            tdata[Q_LSB +: 64] = sx32(sh[63:32]);
         end
         FMT_R32: begin
            sh = 64'(word >> {idx[1:0], 5'd0});
            tdata[I_LSB +: 64] = sx32(sh[31:0]);
         end
         FMT_C16: begin
            sh = 64'(word >> {idx[1:0], 5'd0});
            tdata[I_LSB +: 64] = sx16(sh[15:0]);
            tdata[Q_LSB +: 64] = sx16(sh[31:16]);
         end
         FMT_R16: begin
            sh = 64'(word >> {idx[2:0], 4'd0});
            tdata[I_LSB +: 64] = sx16(sh[15:0]);
         end
         FMT_C8: begin
            sh = 64'(word >> {idx[2:0], 4'd0});
            tdata[I_LSB +: 64] = sx8(sh[7:0]);
            tdata[Q_LSB +: 64] = sx8(sh[15:8]);
         end
         FMT_R8: begin
            sh = 64'(word >> {idx, 3'd0});
            tdata[I_LSB +: 64] = sx8(sh[7:0]);
         end
         default: tdata = '0;
      endcase
   end

endmodule

// File: rtl/tx_fifo_read.sv
// Pops packed 128-bit words from an FWFT FIFO and streams them out one
// sample per beat on AXI-Stream, with FIFO reset control and underrun count.
module tx_fifo_read
   import tx_rx_fifo_pkg::*;
#(
   parameter int UNDERRUN_W = 16
) (
   input  logic                  data_clk,
   input  logic                  data_rstn,
   input  logic                  data_enable,
   input  logic [2:0]            data_format,
   output logic                  fifo_srst,
   input  logic                  fifo_rd_rst_busy,
   input  logic                  fifo_empty,
   input  logic [127:0]          fifo_dout,
   output logic                  fifo_rd_en,
   output logic [127:0]          m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [3:0]            data_read_idx,
   output logic [UNDERRUN_W-1:0] underrun_cnt
);

   logic         srst_ff;
   logic [127:0] word_buf;
   logic         buf_valid;
   logic [3:0]   idx;
   fmt_e         fmt_q;
   logic         run;
   logic         beat;
   logic         last;
   logic [4:0]   spw;
   logic [127:0] unpacked;

   // FIFO reset is held one extra cycle after enable rises via srst_ff.
   assign fifo_srst = srst_ff | ~data_enable;
   assign run       = data_enable & ~fifo_srst & ~fifo_rd_rst_busy;

   assign spw  = samples_per_word(fmt_q);
   assign last = ({1'b0, idx} == spw - 5'd1);
   assign beat = buf_valid & m_axis_tready;

   // Refill on the last beat of a word keeps the stream gapless.
   assign fifo_rd_en = run & ~fifo_empty & (~buf_valid | (beat & last));

   assign m_axis_tvalid = buf_valid;
   assign m_axis_tdata  = buf_valid ? unpacked : '0;
   assign data_read_idx = idx;

   sample_unpack_mux u_unpack (
      .word  (word_buf),
      .idx   (idx),
      .fmt   (fmt_q),
      .tdata (unpacked)
   );

   always_ff @(posedge data_clk or negedge data_rstn) begin
      if (!data_rstn) begin
         srst_ff      <= 1'b1;
         word_buf     <= '0;
         buf_valid    <= 1'b0;
         idx          <= '0;
         fmt_q        <= FMT_C16;
         underrun_cnt <= '0;
      end else begin
         srst_ff <= ~data_enable;
         if (!data_enable) begin
            buf_valid    <= 1'b0;
            idx          <= '0;
            fmt_q        <= fmt_e'(data_format);
            underrun_cnt <= '0;
         end else begin
            if (fifo_rd_en) begin
               word_buf  <= fifo_dout;
               buf_valid <= 1'b1;
               idx       <= '0;
            end else if (beat && !last) begin
               idx <= idx + 4'd1;
            end else if (beat) begin
               buf_valid <= 1'b0;
               idx       <= '0;
            end
            if (run && m_axis_tready && !buf_valid && fifo_empty && !(&underrun_cnt))
               underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
         end
      end
   end

endmodule
